// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
// State encoding, port ids and the default word size.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int WORD_SIZE_DEF = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data port wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req1,
  input  logic req2,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  assign any = req1 | req2;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = req2 ? PORT_DATA : PORT_IF;
    if (req1 && req2)
      winner = ~last_grant;
  end
`else
  logic unused_last;
  assign unused_last = last_grant;
  assign winner = req2 ? PORT_DATA : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 ready1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  input  logic [WORD_SIZE-1:0] wdata2,
  output logic [WORD_SIZE-1:0] rdata2,
  output logic                 ready2,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 err
);

  localparam int CW = $clog2(TIMEOUT);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic                 grant;
  logic                 we_q;
  logic                 timed_out;
  logic                 any;
  logic                 winner;
  logic                 last_grant;
  logic                 req2;
  logic                 hit_to;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  assign req2   = readM2 | writeM2;
  assign hit_to = (cnt == CW'(TIMEOUT - 1));

  mem_arb_pick u_pick (
    .req1       (readM1),
    .req2       (req2),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= PORT_DATA;
    else if (state == IDLE && any)
      last_grant <= winner;
  end
`else
  assign last_grant = PORT_DATA;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any) state_nxt = BUSY;
      BUSY:    if (mem_ack || hit_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fields are latched at grant so requester changes in BUSY are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant     <= PORT_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      timed_out <= 1'b0;
      data1     <= '0;
      rdata2    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant     <= winner;
            we_q      <= (winner == PORT_DATA) & writeM2;
            addr_q    <= (winner == PORT_DATA) ? address2 : address1;
            wdata_q   <= (winner == PORT_DATA) ? wdata2 : '0;
            cnt       <= '0;
            timed_out <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            if (grant == PORT_IF)
              data1 <= mem_rdata;
            else if (!we_q)
              rdata2 <= mem_rdata;
          end else if (hit_to) begin
            timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ready1    = (state == RESP) && (grant == PORT_IF);
  assign ready2    = (state == RESP) && (grant == PORT_DATA);
  assign err       = (state == RESP) && timed_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int W  = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         readM1, readM2, writeM2, mem_ack;
  logic [W-1:0] address1, address2, wdata2, mem_rdata;
  logic [W-1:0] data1, rdata2, mem_addr, mem_wdata;
  logic         ready1, ready2, mem_req, mem_we, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .readM1    (readM1),
    .address1  (address1),
    .data1     (data1),
    .ready1    (ready1),
    .readM2    (readM2),
    .writeM2   (writeM2),
    .address2  (address2),
    .wdata2    (wdata2),
    .rdata2    (rdata2),
    .ready2    (ready2),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder state
  logic [W-1:0] memory [256];
  bit  rand_mode;
  bit  no_ack;
  int  resp_lat;
  int  resp_cnt;

  task automatic step();
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (resp_cnt == resp_lat && !no_ack) begin
        mem_ack = 1'b1;
        if (mem_we)
          memory[mem_addr[7:0]] = mem_wdata;
        else
          mem_rdata = memory[mem_addr[7:0]];
      end
      resp_cnt++;
    end else begin
      resp_cnt = 0;
      if (rand_mode) begin
        resp_lat = $urandom_range(0, 3);
        no_ack   = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 7) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = W'($urandom);
        end
      end
    end
  endtask

  int           busy_n;
  logic [W-1:0] s_a, s_d;
  logic         s_w;

  task automatic wait_port(input int port, input int limit,
                           output int n, output bit ok,
                           output bit other);
    ok = 0; other = 0; n = 0; busy_n = 0;
    repeat (limit) begin
      step();
      n++;
      if (mem_req) begin
        busy_n++;
        s_a = mem_addr; s_w = mem_we; s_d = mem_wdata;
      end
      if ((port == 1 && ready2) || (port == 2 && ready1))
        other = 1;
      if ((port == 1 && ready1) || (port == 2 && ready2)) begin
        ok = 1;
        break;
      end
    end
    if (!ok)
      $display("FAIL wait_port%0d: no ready within %0d cycles", port, limit);
  endtask

  // Transaction-level reference model
  int           cyc = 0;
  int           serving = -1;
  int           start_c, done_c;
  bit           timed, m_last;
  logic [W-1:0] t_addr, t_wdata, e_d1, e_d2;
  logic         t_we;
  logic         e_req, e_r1, e_r2, e_err, fin, p1, p2;
  int           w;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      serving = -1;
      e_d1 = '0; e_d2 = '0;
      m_last = 1'b1;
      chk("rst_mem_req", W'(mem_req), '0);
      chk("rst_ready1", W'(ready1), '0);
      chk("rst_ready2", W'(ready2), '0);
      chk("rst_err", W'(err), '0);
      chk("rst_data1", data1, '0);
      chk("rst_rdata2", rdata2, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
    end else begin
      e_req = 0; e_r1 = 0; e_r2 = 0; e_err = 0; fin = 0;
      if (serving >= 0 && cyc == done_c) begin
        e_r1 = (serving == 0);
        e_r2 = (serving == 1);
        e_err = timed;
        fin = 1;
      end else if (serving >= 0 && cyc >= start_c) begin
        e_req = 1;
      end
      chk("mem_req", W'(mem_req), W'(e_req));
      chk("ready1", W'(ready1), W'(e_r1));
      chk("ready2", W'(ready2), W'(e_r2));
      chk("err", W'(err), W'(e_err));
      chk("data1", data1, e_d1);
      chk("rdata2", rdata2, e_d2);
      if (e_req) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_we", W'(mem_we), W'(t_we));
        if (t_we)
          chk("mem_wdata", mem_wdata, t_wdata);
        if (mem_ack) begin
          done_c = cyc + 1;
          if (!t_we) begin
            if (serving == 0) e_d1 = mem_rdata;
            else              e_d2 = mem_rdata;
          end
        end else if (cyc - start_c == TO - 1) begin
          done_c = cyc + 1;
          timed = 1;
        end
      end
      if (fin) begin
        serving = -1;
      end else if (serving < 0) begin
        p1 = readM1;
        p2 = readM2 | writeM2;
        w = p2 ? 1 : (p1 ? 0 : -1);
`ifdef MEM_ARB_RR_EN
        if (p1 && p2) w = m_last ? 0 : 1;
`endif
        if (w >= 0) begin
          serving = w;
          m_last  = (w == 1);
          t_addr  = (w == 1) ? address2 : address1;
          t_we    = (w == 1) && writeM2;
          t_wdata = wdata2;
          start_c = cyc + 1;
          done_c  = -1;
          timed   = 0;
        end
      end
    end
  end

  int n;
  bit ok, oth;
  int k;

  initial begin
    reset = 1; readM1 = 0; readM2 = 0; writeM2 = 0;
    address1 = '0; address2 = '0; wdata2 = '0;
    mem_ack = 0; mem_rdata = '0;
    rand_mode = 0; no_ack = 0; resp_lat = 0; resp_cnt = 0;
    for (int i = 0; i < 256; i++) memory[i] = W'($urandom);
    memory[8'h10] = 16'hBEEF;
    memory[8'h20] = 16'h2020;
    memory[8'h30] = 16'h3030;
    step(); step();
    reset = 0;
    step();

    // 1: fetch read, ack two cycles after mem_req rises
    resp_lat = 2; readM1 = 1; address1 = 16'h0010;
    wait_port(1, 10, n, ok, oth);
    chk("t1_ready", W'(ok), 16'h1);
    chk("t1_latency", W'(n), 16'd4);
    chk("t1_addr", s_a, 16'h0010);
    chk("t1_we", W'(s_w), 16'h0);
    chk("t1_data1", data1, 16'hBEEF);
    readM1 = 0;
    step();

    // 2: data-port write
    resp_lat = 0; writeM2 = 1;
    address2 = 16'h0200; wdata2 = 16'h1234;
    wait_port(2, 10, n, ok, oth);
    chk("t2_ready", W'(ok), 16'h1);
    chk("t2_we", W'(s_w), 16'h1);
    chk("t2_wdata", s_d, 16'h1234);
    chk("t2_rdata2", rdata2, 16'h0000);
    writeM2 = 0;
    step();

    // 3: simultaneous reads
    resp_lat = 1;
    readM1 = 1; address1 = 16'h0020;
    readM2 = 1; address2 = 16'h0030;
`ifdef MEM_ARB_RR_EN
    wait_port(1, 10, n, ok, oth);
    chk("t3_first_if", W'(ok & ~oth), 16'h1);
    wait_port(2, 10, n, ok, oth);
    chk("t3_second_data", W'(ok & ~oth), 16'h1);
    chk("t3_rdata2", rdata2, 16'h3030);
    wait_port(1, 10, n, ok, oth);
    chk("t3_third_if", W'(ok & ~oth), 16'h1);
    chk("t3_data1", data1, 16'h2020);
    readM1 = 0; readM2 = 0;
`else
    wait_port(2, 10, n, ok, oth);
    chk("t3_first_data", W'(ok & ~oth), 16'h1);
    chk("t3_rdata2", rdata2, 16'h3030);
    readM2 = 0;
    wait_port(1, 10, n, ok, oth);
    chk("t3_then_if", W'(ok & ~oth), 16'h1);
    chk("t3_data1", data1, 16'h2020);
    readM1 = 0;
`endif
    step();

    // 4: memory never answers
    no_ack = 1; readM1 = 1; address1 = 16'h0044;
    wait_port(1, 90, n, ok, oth);
    chk("t4_ready", W'(ok), 16'h1);
    chk("t4_busy_cycles", W'(busy_n), 16'd64);
    chk("t4_err", W'(err), 16'h1);
    chk("t4_data1_kept", data1, 16'h2020);
    readM1 = 0; no_ack = 0;
    step();

    // 5: reset in the middle of BUSY
    no_ack = 1; readM1 = 1; address1 = 16'h0010;
    step(); step(); step();
    chk("t5_busy", W'(mem_req), 16'h1);
    #2 reset = 1; readM1 = 0;
    #1 chk("t5_req_drop", W'(mem_req), 16'h0);
    step();
    reset = 0; no_ack = 0;
    repeat (3) begin
      step();
      chk("t5_no_ready", W'(ready1 | ready2), 16'h0);
    end
    resp_lat = 1; readM1 = 1; address1 = 16'h0010;
    wait_port(1, 10, n, ok, oth);
    chk("t5_ready", W'(ok), 16'h1);
    chk("t5_latency", W'(n), 16'd3);
    chk("t5_data1", data1, 16'hBEEF);
    readM1 = 0;
    step();

    // 6: stray ack while idle
    mem_ack = 1; mem_rdata = 16'hFFFF;
    repeat (3) begin
      step();
      chk("t6_idle", W'({mem_req, ready1, ready2}), 16'h0);
    end
    chk("t6_data1", data1, 16'hBEEF);

    // Random traffic
    rand_mode = 1;
    repeat (3000) begin
      step();
      if (ready1) readM1 = 0;
      else if (!readM1 && $urandom_range(0, 2) == 0) begin
        readM1 = 1;
        address1 = W'($urandom_range(0, 63));
      end
      if (ready2) begin
        readM2 = 0; writeM2 = 0;
      end else if (!readM2 && !writeM2 &&
                   $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        readM2   = (k != 1);
        writeM2  = (k != 0);
        address2 = W'($urandom_range(0, 63));
        wdata2   = W'($urandom);
      end
    end
    repeat (200) begin
      step();
      if (ready1) readM1 = 0;
      if (ready2) begin
        readM2 = 0; writeM2 = 0;
      end
    end
    chk("drain", W'({readM1, readM2, writeM2}), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
